// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation encodings
// and a small decode helper used by the block and its bench.
package shift_reg_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SHR  = 2'b01;
    localparam logic [1:0] MODE_SHL  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Either shift direction advances the shift counter.
    function automatic logic mode_is_shift(input logic [1:0] m);
        return (m == MODE_SHR) || (m == MODE_SHL);
    endfunction

endpackage

// File: rtl/dff_cell.sv
// One storage bit of the shift register: enable flop with synchronous
// active-high reset to a per-instance value and a complemented output.
module dff_cell #(
    parameter logic RST_BIT = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q,
    output logic q_bar
);

    logic q_q;
    logic q_d;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = d;
        end
    end

    // Reset wins over enable so a reset edge always restores RST_BIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= RST_BIT;
        end else begin
            q_q <= q_d;
        end
    end

    assign q     = q_q;
    assign q_bar = ~q_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left (with rotate), parallel
// load, plus a saturating shift counter and a one-shot done pulse.
module univ_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       rot,
    input  logic                       sin_r,
    input  logic                       sin_l,
    input  logic [WIDTH-1:0]           d,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           q_bar,
    output logic                       sout_r,
    output logic                       sout_l,
    output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
    output logic                       done
);

    localparam int               CNT_W   = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] q_bar_w;
    logic             cell_en;
    logic             fill_msb;
    logic             fill_lsb;

    // HOLD needs no write; gating it keeps the cells idle.
    assign cell_en  = en && (mode != MODE_HOLD);
    assign fill_msb = rot ? q_w[0]       : sin_r;
    assign fill_lsb = rot ? q_w[WIDTH-1] : sin_l;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic from_hi;
        logic from_lo;
        logic nxt_d;

        if (i == WIDTH - 1) begin : g_top
            assign from_hi = fill_msb;
        end else begin : g_mid_hi
            assign from_hi = q_w[i+1];
        end

        if (i == 0) begin : g_bot
            assign from_lo = fill_lsb;
        end else begin : g_mid_lo
            assign from_lo = q_w[i-1];
        end

        always_comb begin
            nxt_d = q_w[i];
            case (mode)
                MODE_SHR:  nxt_d = from_hi;
                MODE_SHL:  nxt_d = from_lo;
                MODE_LOAD: nxt_d = d[i];
                default:   nxt_d = q_w[i];
            endcase
        end

        dff_cell #(
            .RST_BIT (RST_VAL[i])
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .en    (cell_en),
            .d     (nxt_d),
            .q     (q_w[i]),
            .q_bar (q_bar_w[i])
        );
    end

    logic [CNT_W-1:0] shift_cnt_q;
    logic [CNT_W-1:0] shift_cnt_d;
    logic             done_q;
    logic             done_d;

    // done fires only on the WIDTH-1 -> WIDTH step; once saturated the
    // counter stops, so the pulse cannot recur until a LOAD or reset.
    always_comb begin
        shift_cnt_d = shift_cnt_q;
        done_d      = 1'b0;
        if (en) begin
            if (mode == MODE_LOAD) begin
                shift_cnt_d = '0;
            end else if (mode_is_shift(mode) && (shift_cnt_q != CNT_MAX)) begin
                shift_cnt_d = shift_cnt_q + 1'b1;
                done_d      = (shift_cnt_q == CNT_MAX - 1'b1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_cnt_q <= '0;
            done_q      <= 1'b0;
        end else begin
            shift_cnt_q <= shift_cnt_d;
            done_q      <= done_d;
        end
    end

    assign q         = q_w;
    assign q_bar     = q_bar_w;
    assign sout_r    = q_w[0];
    assign sout_l    = q_w[WIDTH-1];
    assign shift_cnt = shift_cnt_q;
    assign done      = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: two instances (reset values 0 and 8'h5A) driven
// in lockstep, checked every cycle against an arithmetic reference model.
module tb_univ_shift_reg;
    import shift_reg_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst   = 1'b1;
    logic       en    = 1'b0;
    logic [1:0] mode  = MODE_HOLD;
    logic       rot   = 1'b0;
    logic       sin_r = 1'b0;
    logic       sin_l = 1'b0;
    logic [7:0] d     = 8'h00;

    logic [7:0] q0, qb0, q1, qb1;
    logic       sr0, sl0, sr1, sl1, done0, done1;
    logic [3:0] cnt0, cnt1;

    univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot),
        .sin_r(sin_r), .sin_l(sin_l), .d(d),
        .q(q0), .q_bar(qb0), .sout_r(sr0), .sout_l(sl0),
        .shift_cnt(cnt0), .done(done0)
    );

    univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h5A)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .rot(rot),
        .sin_r(sin_r), .sin_l(sin_l), .d(d),
        .q(q1), .q_bar(qb1), .sout_r(sr1), .sout_l(sl1),
        .shift_cnt(cnt1), .done(done1)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_q0, m_q1, m_cnt, m_done;
    int done_seen;

    function automatic int ref_shift(input int v, input bit right, input bit r,
                                     input bit sr, input bit sl);
        int in_bit;
        if (right) begin
            in_bit = r ? (v % 2) : int'(sr);
            return (v / 2) + in_bit * 128;
        end
        in_bit = r ? (v / 128) : int'(sl);
        return ((v * 2) % 256) + in_bit;
    endfunction

    task automatic model_update();
        if (rst) begin
            m_q0 = 0; m_q1 = 'h5A; m_cnt = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (en) begin
                if (mode == MODE_LOAD) begin
                    m_q0 = int'(d); m_q1 = int'(d); m_cnt = 0;
                end else if (mode == MODE_SHR || mode == MODE_SHL) begin
                    m_q0 = ref_shift(m_q0, mode == MODE_SHR, rot, sin_r, sin_l);
                    m_q1 = ref_shift(m_q1, mode == MODE_SHR, rot, sin_r, sin_l);
                    if (m_cnt == 7) m_done = 1;
                    if (m_cnt < 8) m_cnt++;
                end
            end
        end
    endtask

    task automatic check_all();
        chk("q0",      q0,    m_q0);
        chk("qbar0",   qb0,   255 - m_q0);
        chk("sout_r0", sr0,   m_q0 % 2);
        chk("sout_l0", sl0,   m_q0 / 128);
        chk("cnt0",    cnt0,  m_cnt);
        chk("done0",   done0, m_done);
        chk("q1",      q1,    m_q1);
        chk("qbar1",   qb1,   255 - m_q1);
        chk("sout_r1", sr1,   m_q1 % 2);
        chk("sout_l1", sl1,   m_q1 / 128);
        chk("cnt1",    cnt1,  m_cnt);
        chk("done1",   done1, m_done);
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic rt, input logic sr, input logic sl,
                        input logic [7:0] dd);
        rst = r; en = e; mode = m; rot = rt; sin_r = sr; sin_l = sl; d = dd;
        @(posedge clk);
        model_update();
        #1;
        check_all();
        if (done0) done_seen++;
    endtask

    task automatic load(input logic [7:0] v);
        step(1'b0, 1'b1, MODE_LOAD, 1'b0, 1'b0, 1'b0, v);
    endtask

    int sout_seq[8] = '{1, 0, 1, 0, 0, 1, 0, 1};

    initial begin
        // Reset with en=0 and LOAD of all-ones must still clear.
        step(1'b1, 1'b0, MODE_LOAD, 1'b0, 1'b0, 1'b0, 8'hFF);
        chk("rst_q",    q0,    8'h00);
        chk("rst_qbar", qb0,   8'hFF);
        chk("rst_cnt",  cnt0,  0);
        chk("rst_done", done0, 0);
        chk("rst_q1",   q1,    8'h5A);

        // A5 shifted right with zero fill.
        load(8'hA5);
        done_seen = 0;
        for (int i = 0; i < 8; i++) begin
            chk("sout_seq", sr0, sout_seq[i]);
            step(1'b0, 1'b1, MODE_SHR, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        chk("shr_final", q0, 8'h00);
        step(1'b0, 1'b1, MODE_HOLD, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("shr_done_cnt", done_seen, 1);

        // 81 rotated left.
        load(8'h81);
        done_seen = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, MODE_SHL, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("rotl3", q0, 8'h0C);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, MODE_SHL, 1'b1, 1'b1, 1'b1, 8'h00);
        chk("rotl8", q0, 8'h81);
        step(1'b0, 1'b1, MODE_SHL, 1'b1, 1'b0, 1'b0, 8'h00);
        chk("rot_done_cnt", done_seen, 1);

        // Disabled shifts hold; then counter saturates.
        load(8'h3C);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, MODE_SHR, 1'b0, 1'b1, 1'b1, 8'h00);
        chk("en0_q",   q0,   8'h3C);
        chk("en0_cnt", cnt0, 0);
        done_seen = 0;
        for (int i = 0; i < 12; i++)
            step(1'b0, 1'b1, MODE_SHL, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'h00);
        chk("sat_cnt",  cnt0, 8);
        chk("sat_done", done_seen, 1);

        // Reset mid-sequence discards the count.
        load(8'hF0);
        done_seen = 0;
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, MODE_SHR, 1'b0, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b1, MODE_SHL, 1'b0, 1'b0, 1'b0, 8'h00);
        chk("mid_rst_q",     q0,    8'h00);
        chk("mid_rst_cnt",   cnt0,  0);
        chk("mid_rst_done",  done0, 0);
        chk("mid_rst_q1",    q1,    8'h5A);
        chk("mid_rst_qbar1", qb1,   8'hA5);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, MODE_SHL, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("mid_rst_nodone", done_seen, 0);

        // Random mix: mostly shifts, occasional loads, holds and resets.
        for (int i = 0; i < 600; i++) begin
            int  pick;
            logic [1:0] m;
            pick = $urandom_range(0, 99);
            if (pick < 35)      m = MODE_SHR;
            else if (pick < 70) m = MODE_SHL;
            else if (pick < 85) m = MODE_HOLD;
            else                m = MODE_LOAD;
            step(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 9) != 0), m,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
